// File: rtl/lsm_sequencer.sv
// Load/store-multiple sequencer: moves one register per cycle between RF and data memory.
// Define LSM_POSTINC_EN for post-increment (compact) addressing; default is sparse base+stride*k.
module lsm_sequencer #(
  parameter int unsigned ADDR_STRIDE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_lm,
  input  logic        start_sm,
  input  logic [15:0] base_addr,
  input  logic [7:0]  reg_mask,
  output logic [2:0]  rf_raddr,
  input  logic [15:0] rf_rdata,
  output logic        rf_wen,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [15:0] dm_addr,
  output logic [15:0] dm_wdata,
  output logic        dm_read,
  output logic        dm_write,
  input  logic [15:0] dm_data,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  // state | meaning
  // IDLE  | waiting for start_lm / start_sm
  // LOAD  | one memory->register transfer per cycle until mask empties
  // STORE | one register->memory transfer per cycle until mask empties
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, STORE = 2'd2} state_t;

  localparam logic [15:0] STRIDE = 16'(ADDR_STRIDE);

  state_t      state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [7:0]  mask_q, mask_d;
  logic        done_q, done_d;

  logic [2:0]  k;
  logic        xfer;
  logic [15:0] xfer_addr;

  always_comb begin
    k = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i]) k = 3'(i);
    end
  end

  assign xfer = (state_q != IDLE) && (mask_q != 8'd0);

`ifdef LSM_POSTINC_EN
  assign xfer_addr = ptr_q;
`else
  assign xfer_addr = ptr_q + STRIDE * {13'd0, k};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= 16'd0;
      mask_q  <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    mask_d   = mask_q;
    done_d   = 1'b0;
    rf_raddr = 3'd0;
    rf_wen   = 1'b0;
    rf_waddr = 3'd0;
    rf_wdata = 16'd0;
    dm_addr  = 16'd0;
    dm_wdata = 16'd0;
    dm_read  = 1'b0;
    dm_write = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_lm || start_sm) begin
          state_d = start_lm ? LOAD : STORE;
          ptr_d   = base_addr;
          mask_d  = reg_mask;
        end
      end
      LOAD, STORE: begin
        if (xfer) begin
          mask_d  = mask_q & ~(8'd1 << k);
          dm_addr = xfer_addr;
`ifdef LSM_POSTINC_EN
          ptr_d   = ptr_q + STRIDE;
`endif
          if (state_q == LOAD) begin
            dm_read  = 1'b1;
            rf_wen   = 1'b1;
            rf_waddr = k;
            rf_wdata = dm_data;
          end else begin
            rf_raddr = k;
            dm_write = 1'b1;
            dm_wdata = rf_rdata;
          end
        end
        // an empty mask (including one captured at start) finishes here
        if (mask_d == 8'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign stall = busy | start_lm | start_sm;
  assign done  = done_q;

endmodule

// File: tb/tb_lsm_sequencer.sv
// Randomized self-checking bench for lsm_sequencer with an abstract transfer-list model.
module tb_lsm_sequencer;
  localparam int STRIDE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_lm, start_sm;
  logic [15:0] base_addr;
  logic [7:0]  reg_mask;
  logic [2:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic        rf_wen;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_read, dm_write;
  logic [15:0] dm_data;
  logic        busy, stall, done;

  lsm_sequencer #(.ADDR_STRIDE(STRIDE)) dut (
    .clk(clk), .rst(rst), .start_lm(start_lm), .start_sm(start_sm),
    .base_addr(base_addr), .reg_mask(reg_mask),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_wen(rf_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_read(dm_read),
    .dm_write(dm_write), .dm_data(dm_data),
    .busy(busy), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        wen;
    logic [2:0]  idx;
    logic [15:0] addr;
    logic [15:0] data;
  } entry_t;

  int checks = 0;
  int failures = 0;

  // memory and register file attached to the DUT; untouched locations hold a fixed pattern
  logic [15:0] mem [logic [15:0]];
  logic [15:0] rf  [logic [2:0]];
  logic [15:0] exp_mem [logic [15:0]];
  logic [15:0] exp_rf  [logic [2:0]];

  entry_t log_q[$];
  int done_cnt = 0;
  int both_cnt = 0;

  function automatic logic [15:0] mem_init(logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction
  function automatic logic [15:0] rf_init(logic [2:0] i);
    return 16'h1F0F + 16'h1111 * {13'd0, i};
  endfunction
  function automatic logic [15:0] mem_rd(logic [15:0] a);
    return mem.exists(a) ? mem[a] : mem_init(a);
  endfunction
  function automatic logic [15:0] rf_rd(logic [2:0] i);
    return rf.exists(i) ? rf[i] : rf_init(i);
  endfunction
  function automatic logic [15:0] emem_rd(logic [15:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : mem_init(a);
  endfunction
  function automatic logic [15:0] erf_rd(logic [2:0] i);
    return exp_rf.exists(i) ? exp_rf[i] : rf_init(i);
  endfunction

  always @(posedge clk) begin
    if (dm_write) mem[dm_addr] = dm_wdata;
    if (rf_wen) rf[rf_waddr] = rf_wdata;
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      dm_data  = mem_rd(dm_addr);
      rf_rdata = rf_rd(rf_raddr);
    end
  end

  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (dm_read === 1'b1 && dm_write === 1'b1) both_cnt++;
      if (dm_read || dm_write || rf_wen) begin
        e.rd   = dm_read;
        e.wr   = dm_write;
        e.wen  = rf_wen;
        e.idx  = dm_read ? rf_waddr : rf_raddr;
        e.addr = dm_addr;
        e.data = dm_read ? rf_wdata : dm_wdata;
        log_q.push_back(e);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
      $error("%s: got %h want %h", tag, got, want);
    end
  endtask

  // expected transfer list from the architectural rules, applied to the model state
  task automatic model_op(input bit lm, input logic [15:0] b, input logic [7:0] m,
                          input int limit, output entry_t q[$]);
    int n = 0;
    q.delete();
    for (int kk = 0; kk < 8; kk++) begin
      entry_t e;
      logic [15:0] a;
      if (!m[kk] || n >= limit) continue;
`ifdef LSM_POSTINC_EN
      a = b + 16'(STRIDE * n);
`else
      a = b + 16'(STRIDE * kk);
`endif
      e.idx  = 3'(kk);
      e.addr = a;
      if (lm) begin
        e.rd = 1'b1; e.wr = 1'b0; e.wen = 1'b1;
        e.data = emem_rd(a);
        exp_rf[3'(kk)] = e.data;
      end else begin
        e.rd = 1'b0; e.wr = 1'b1; e.wen = 1'b0;
        e.data = erf_rd(3'(kk));
        exp_mem[a] = e.data;
      end
      q.push_back(e);
      n++;
    end
  endtask

  task automatic compare_log(input string tag, input int first, input entry_t q[$]);
    chk({tag, "_count"}, 64'(log_q.size() - first), 64'(q.size()));
    for (int i = 0; i < q.size() && first + i < log_q.size(); i++)
      chk({tag, "_xfer"}, 64'(log_q[first + i]), 64'(q[i]));
    for (int i = 0; i < 8; i++)
      chk({tag, "_rf"}, 64'(rf_rd(3'(i))), 64'(erf_rd(3'(i))));
    foreach (q[i])
      chk({tag, "_mem"}, 64'(mem_rd(q[i].addr)), 64'(emem_rd(q[i].addr)));
  endtask

  task automatic run_op(input string tag, input bit lm, input bit sm,
                        input logic [15:0] b, input logic [7:0] m, input bit inj);
    entry_t q[$];
    int first, d0, n, lat;
    model_op(lm, b, m, 8, q);
    lat = (m == 8'd0) ? 2 : $countones(m) + 1;
    first = log_q.size();
    d0 = done_cnt;
    @(posedge clk); #1;
    start_lm = lm; start_sm = sm; base_addr = b; reg_mask = m;
    #1 chk({tag, "_stall"}, 64'(stall), 64'd1);
    @(posedge clk); #1;
    start_lm = 1'b0; start_sm = 1'b0;
    base_addr = 16'($urandom); reg_mask = 8'($urandom);
    if (inj) begin start_lm = 1'b1; start_sm = 1'b1; end
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      start_lm = 1'b0; start_sm = 1'b0;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_done_low"}, 64'(done), 64'd0);
    compare_log(tag, first, q);
  endtask

  initial begin
    entry_t q[$];
    int first, d0;
    logic [15:0] b;
    rst = 1'b0; start_lm = 1'b0; start_sm = 1'b0; base_addr = 16'd0; reg_mask = 8'd0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dm_write", 64'(dm_write), 64'd0);
    chk("rst_rf_wen", 64'(rf_wen), 64'd0);
    chk("rst_dm_read", 64'(dm_read), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    run_op("sm_0100_05", 1'b0, 1'b1, 16'h0100, 8'h05, 1'b0);
    run_op("lm_0200_81", 1'b1, 1'b0, 16'h0200, 8'h81, 1'b0);
    run_op("lm_wrap", 1'b1, 1'b0, 16'hFFFE, 8'h03, 1'b0);
    chk("wrap_first_addr", 64'(log_q[log_q.size() - 2].addr), 64'hFFFE);
    chk("wrap_second_addr", 64'(log_q[log_q.size() - 1].addr), 64'h0000);
    run_op("lm_zero", 1'b1, 1'b0, 16'h1234, 8'h00, 1'b0);
    run_op("sm_zero", 1'b0, 1'b1, 16'h4321, 8'h00, 1'b0);
    run_op("both_start", 1'b1, 1'b1, 16'h0300, 8'h5A, 1'b0);
    run_op("busy_start", 1'b0, 1'b1, 16'h0400, 8'h3C, 1'b1);
    run_op("sm_full", 1'b0, 1'b1, 16'h0500, 8'hFF, 1'b0);

    // reset after the first store transfer of a full mask
    b = 16'h0600;
    model_op(1'b0, b, 8'hFF, 1, q);
    first = log_q.size();
    d0 = done_cnt;
    @(posedge clk); #1;
    start_sm = 1'b1; base_addr = b; reg_mask = 8'hFF;
    @(posedge clk); #1;
    start_sm = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_stall", 64'(stall), 64'd0);
    chk("midrst_dm_write", 64'(dm_write), 64'd0);
    chk("midrst_rf_wen", 64'(rf_wen), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("midrst_untouched", 64'(mem_rd(b + 16'(STRIDE))), 64'(emem_rd(b + 16'(STRIDE))));
    compare_log("midrst", first, q);

    for (int i = 0; i < 16; i++) begin
      bit lm;
      lm = 1'($urandom);
      run_op(lm ? "rand_lm" : "rand_sm", lm, ~lm, 16'($urandom), 8'($urandom), 1'($urandom));
    end

    chk("no_read_write_overlap", 64'(both_cnt), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsm_sequencer.md
LSM_SEQUENCER -- requirements
Module: lsm_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_STRIDE, default 2: byte increment between consecutive 16-bit words.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-003 The block SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port start_lm, input, 1: one-cycle request to begin a load-multiple.
REQ-005 The block SHALL have port start_sm, input, 1: one-cycle request to begin a store-multiple.
REQ-006 The block SHALL have port base_addr, input, 16: starting byte address, sampled with start.
REQ-007 The block SHALL have port reg_mask, input, 8: bit k set means register Rk is transferred; sampled with start.
REQ-008 The block SHALL have port rf_raddr, output, 3: register-file read index for store data.
REQ-009 The block SHALL have port rf_rdata, input, 16: combinational register-file read data for rf_raddr.
REQ-010 The block SHALL have port rf_wen, output, 1: register-file write enable.
REQ-011 The block SHALL have port rf_waddr, output, 3: register-file write index.
REQ-012 The block SHALL have port rf_wdata, output, 16: register-file write data.
REQ-013 The block SHALL have port dm_addr, output, 16: data-memory byte address.
REQ-014 The block SHALL have port dm_wdata, output, 16: data-memory write data.
REQ-015 The block SHALL have port dm_read, output, 1: data-memory MemRead.
REQ-016 The block SHALL have port dm_write, output, 1: data-memory MemWrite.
REQ-017 The block SHALL have port dm_data, input, 16: combinational data-memory read data.
REQ-018 The block SHALL have port busy, output, 1: high when the state is not IDLE.
REQ-019 The block SHALL have port stall, output, 1: combinational, equal to busy OR start_lm OR start_sm; freezes the upstream pipeline.
REQ-020 The block SHALL have port done, output, 1: registered one-cycle completion pulse.

Function
REQ-021 The state machine SHALL have three states, IDLE, LOAD and STORE, held in registers with ptr[15:0], mask[7:0] and done.
REQ-022 In IDLE, start_lm SHALL capture base_addr and reg_mask and move the state to LOAD.
REQ-023 In IDLE, start_sm without start_lm SHALL capture base_addr and reg_mask and move the state to STORE; when both are asserted, start_lm SHALL win.
REQ-024 Start pulses SHALL be ignored when the state is not IDLE.
REQ-025 In LOAD or STORE, each cycle SHALL transfer the register whose index k is the lowest set bit of mask.
REQ-026 A LOAD cycle SHALL drive dm_read=1, dm_addr=address(k), rf_wen=1, rf_waddr=k and rf_wdata=dm_data in the same cycle.
REQ-027 A STORE cycle SHALL drive rf_raddr=k, dm_write=1, dm_addr=address(k) and dm_wdata=rf_rdata; the memory commits the write at the next posedge.
REQ-028 At each transfer posedge, bit k SHALL be cleared in mask; when the cleared mask becomes 0, the state SHALL go to IDLE and done SHALL be 1 for the following cycle.
REQ-029 Latency from the start cycle to the done cycle SHALL be popcount(reg_mask)+1 cycles.
REQ-030 A start with reg_mask=0 SHALL enter LOAD or STORE, perform no transfer, and return to IDLE with done asserted after 2 cycles.
REQ-031 Address arithmetic SHALL be modulo 2^16, so wrap from 0xFFFE to 0x0000 is legal.
REQ-032 Outside active transfers, dm_read, dm_write and rf_wen SHALL be 0 and dm_addr, dm_wdata and rf_wdata SHALL be 0.
REQ-033 The block SHALL never assert dm_read and dm_write in the same cycle.

Reset
REQ-034 When rst is 0, the block SHALL asynchronously set state=IDLE, ptr=0, mask=0 and done=0, with busy=0, dm_write=0 and rf_wen=0 immediately.
REQ-035 Reset asserted mid-sequence SHALL abort the sequence with no further transfers and no done pulse; a partial register or memory update SHALL be kept.

Configuration
REQ-036 When macro LSM_POSTINC_EN is defined, address(k) SHALL be ptr, and ptr SHALL advance by ADDR_STRIDE per transfer, giving compact consecutive words.
REQ-037 When LSM_POSTINC_EN is undefined, address(k) SHALL be base + ADDR_STRIDE*k, giving sparse slots indexed by register number; ptr SHALL hold base.

Verification
REQ-038 Reset with the sequence idle: rst=0 at any time -> busy=0, stall=0, done=0, dm_write=0 and rf_wen=0 asynchronously.
REQ-039 SM from idle: start_sm with base=0x0100 and mask=0x05 (sparse) -> writes R0 to 0x0100 and R2 to 0x0104, 2 transfer cycles, done on cycle 3.
REQ-040 LM with LSM_POSTINC_EN: start_lm with base=0x0200, mask=0x81, memory 0x0200=0x1111 and 0x0202=0x2222 -> R0=0x1111, R7=0x2222.
REQ-041 Address wrap with LSM_POSTINC_EN: start_lm with base=0xFFFE and mask=0x03 -> dm_addr 0xFFFE, then 0x0000.
REQ-042 Zero mask: start_lm with mask=0x00 -> no dm_read, no rf_wen, done 2 cycles after start.
REQ-043 Reset and conflicts: rst=0 after the first transfer of mask=0xFF -> exactly one write observed, no done; simultaneous start_lm and start_sm -> LOAD; a start while busy is ignored.
